// File: rtl/axis_pkg.sv
// -----------------------------------------------------------------------------
// axis_pkg
// Shared definitions for the AXI-stream style frame arbiter:
//   - fsm_state_t : arbiter FSM state encoding (IDLE / BUSY)
//   - SAT_W       : width of the beat counter and the saturating event counters
//   - popcount8   : number of set bits in an 8-bit vector (K is at most 8)
//   - sat_add     : SAT_W-bit add of a small amount that sticks at all-ones
// -----------------------------------------------------------------------------
package axis_pkg;

   localparam int SAT_W = 16;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } fsm_state_t;

   function automatic logic [3:0] popcount8(input logic [7:0] vec);
      logic [3:0] cnt;
      cnt = 4'd0;
      for (int i = 0; i < 8; i++) begin
         cnt = cnt + {3'd0, vec[i]};
      end
      return cnt;
   endfunction

   function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] val,
                                                input logic [3:0]       amt);
      logic [SAT_W:0] sum;
      sum = {1'b0, val} + {{(SAT_W-3){1'b0}}, amt};
      if (sum[SAT_W]) begin
         return {SAT_W{1'b1}};
      end else begin
         return sum[SAT_W-1:0];
      end
   endfunction

endpackage

// File: rtl/axis_frame_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin search. Starting just above last_owner and
// wrapping modulo K, returns the first requester whose req bit is set.
// Ports:
//   req        [K-1:0]     candidate vector
//   last_owner [IDX_W-1:0] index of the previous owner (search starts above it)
//   pick       [K-1:0]     one-hot winner, all zero when no candidate
//   pick_idx   [IDX_W-1:0] binary index of the winner
//   found                  at least one candidate present
// -----------------------------------------------------------------------------
module rr_pick
   import axis_pkg::*;
#(
   parameter int K     = 4,
   parameter int IDX_W = $clog2(K)
) (
   input  logic [K-1:0]     req,
   input  logic [IDX_W-1:0] last_owner,
   output logic [K-1:0]     pick,
   output logic [IDX_W-1:0] pick_idx,
   output logic             found
);

   logic [IDX_W-1:0] cand_s;

   // Walk the K positions after last_owner and latch the first hit.
   always_comb begin
      pick     = {K{1'b0}};
      pick_idx = {IDX_W{1'b0}};
      found    = 1'b0;
      cand_s   = {IDX_W{1'b0}};
      for (int step = 1; step <= K; step++) begin
         cand_s = IDX_W'((int'(last_owner) + step) % K);
         if (!found && req[cand_s]) begin
            found          = 1'b1;
            pick[cand_s]   = 1'b1;
            pick_idx       = cand_s;
         end else begin
         end
      end
   end

endmodule

// File: rtl/axis_frame_arbiter.sv
// -----------------------------------------------------------------------------
// axis_frame_arbiter
// Frame-granular round-robin arbiter of K beat streams onto one output stream.
// A requester wins only with a first-of-frame beat; it then owns the output for
// FRAME_BEATS beats. Misaligned beats seen while idle are drained and counted;
// an unexpected first-of-frame beat inside a frame truncates it (abort).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   s_axis_tvalid [K-1:0]    per-requester beat valid
//   s_axis_tdata  [K*N-1:0]  per-requester beat data (requester i at [i*N +: N])
//   s_axis_tfirst [K-1:0]    per-requester first-beat-of-frame flag
//   s_axis_tnext  [K-1:0]    requester beat consumed this cycle
//   m_axis_tnext             downstream consumes the presented beat
//   m_axis_tdata/tfirst/tvalid  granted beat
//   grant         [K-1:0]    one-hot current owner, zero when idle
//   drop_count, abort_count  saturating 16-bit event counters
// -----------------------------------------------------------------------------
module axis_frame_arbiter
   import axis_pkg::*;
#(
   parameter int N           = 4,
   parameter int K           = 4,
   parameter int FRAME_BEATS = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [K-1:0]     s_axis_tvalid,
   input  logic [K*N-1:0]   s_axis_tdata,
   input  logic [K-1:0]     s_axis_tfirst,
   output logic [K-1:0]     s_axis_tnext,
   input  logic             m_axis_tnext,
   output logic [N-1:0]     m_axis_tdata,
   output logic             m_axis_tfirst,
   output logic             m_axis_tvalid,
   output logic [K-1:0]     grant,
   output logic [15:0]      drop_count,
   output logic [15:0]      abort_count
);

   localparam int               IDX_W     = $clog2(K);
   localparam logic [SAT_W-1:0] LAST_BEAT = SAT_W'(FRAME_BEATS - 1);

   typedef struct packed {
      fsm_state_t       fsm;
      logic [K-1:0]     grant;
      logic [IDX_W-1:0] owner;
      logic [SAT_W-1:0] count;       // beats still to go after the current one
      logic [IDX_W-1:0] last_owner;
      logic [SAT_W-1:0] drop_count;
      logic [SAT_W-1:0] abort_count;
   } arb_state_t;

   // last_owner = K-1 so that requester 0 is searched first after reset.
   localparam arb_state_t RESET_STATE = '{
      fsm:         ST_IDLE,
      grant:       {K{1'b0}},
      owner:       {IDX_W{1'b0}},
      count:       {SAT_W{1'b0}},
      last_owner:  IDX_W'(K - 1),
      drop_count:  {SAT_W{1'b0}},
      abort_count: {SAT_W{1'b0}}
   };

   arb_state_t       state_r;
   arb_state_t       next_s;

   logic             busy_s;
   logic             own_valid_s;
   logic             own_first_s;
   logic [N-1:0]     own_data_s;
   logic             abort_s;
   logic             xfer_s;
   logic [K-1:0]     cand_s;
   logic [K-1:0]     drop_mask_s;
   logic [7:0]       drop_pad_s;
   logic [K-1:0]     pick_s;
   logic [IDX_W-1:0] pick_idx_s;
   logic             found_s;

   assign busy_s      = (state_r.fsm == ST_BUSY);
   assign cand_s      = s_axis_tvalid & s_axis_tfirst;
   assign drop_mask_s = s_axis_tvalid & ~s_axis_tfirst;

   rr_pick #(
      .K     (K),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req        (cand_s),
      .last_owner (state_r.last_owner),
      .pick       (pick_s),
      .pick_idx   (pick_idx_s),
      .found      (found_s)
   );

   // Select the owner's input lanes and detect a frame that restarts early.
   always_comb begin
      own_valid_s = s_axis_tvalid[state_r.owner];
      own_first_s = s_axis_tfirst[state_r.owner];
      own_data_s  = s_axis_tdata[int'(state_r.owner) * N +: N];
      // A first-of-frame beat anywhere but the opening slot truncates the frame;
      // with FRAME_BEATS == 1 every beat is the opening slot, so this never fires.
      abort_s     = busy_s && own_valid_s && own_first_s && (state_r.count != LAST_BEAT);
   end

   // Output stream and per-requester consume strobes (zero-latency pass-through).
   always_comb begin
      m_axis_tvalid = !rst && busy_s && own_valid_s && !abort_s;
      m_axis_tfirst = !rst && busy_s && own_first_s;
      if (!rst && busy_s) begin
         m_axis_tdata = own_data_s;
      end else begin
         m_axis_tdata = {N{1'b0}};
      end
      xfer_s = m_axis_tvalid && m_axis_tnext;
      if (rst) begin
         s_axis_tnext = {K{1'b0}};
      end else if (busy_s) begin
         s_axis_tnext = state_r.grant & {K{xfer_s}};
      end else begin
         // While idle every misaligned beat is drained immediately.
         s_axis_tnext = drop_mask_s;
      end
   end

   // Next-state computation for the whole registered state.
   always_comb begin
      next_s     = state_r;
      drop_pad_s = 8'd0;
      drop_pad_s[K-1:0] = drop_mask_s;
      case (state_r.fsm)
         ST_IDLE: begin
            next_s.drop_count = sat_add(state_r.drop_count, popcount8(drop_pad_s));
            if (found_s) begin
               next_s.fsm   = ST_BUSY;
               next_s.grant = pick_s;
               next_s.owner = pick_idx_s;
               next_s.count = LAST_BEAT;
            end else begin
            end
         end
         ST_BUSY: begin
            if (abort_s) begin
               // The offending beat is left pending so it can compete again.
               next_s.fsm         = ST_IDLE;
               next_s.grant       = {K{1'b0}};
               next_s.count       = {SAT_W{1'b0}};
               next_s.last_owner  = state_r.owner;
               next_s.abort_count = sat_add(state_r.abort_count, 4'd1);
            end else if (xfer_s) begin
               if (state_r.count == {SAT_W{1'b0}}) begin
                  next_s.fsm        = ST_IDLE;
                  next_s.grant      = {K{1'b0}};
                  next_s.last_owner = state_r.owner;
               end else begin
                  next_s.count = state_r.count - 16'd1;
               end
            end else begin
            end
         end
         default: begin
            next_s = RESET_STATE;
         end
      endcase
   end

   // State register with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= RESET_STATE;
      end else begin
         state_r <= next_s;
      end
   end

   assign grant       = state_r.grant;
   assign drop_count  = state_r.drop_count;
   assign abort_count = state_r.abort_count;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axis_frame_arbiter
// Two arbiters (FRAME_BEATS = 2 and 4) driven by frame-oriented source models.
// A frame-level reference model is compared against both on every falling edge;
// directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_axis_frame_arbiter;

   localparam int N  = 4;
   localparam int K  = 4;
   localparam int NI = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [K-1:0]   s_valid  [NI];
   logic [K*N-1:0] s_data   [NI];
   logic [K-1:0]   s_first  [NI];
   logic           m_next   [NI];
   logic [K-1:0]   s_tnext  [NI];
   logic [N-1:0]   m_data   [NI];
   logic           m_first  [NI];
   logic           m_valid  [NI];
   logic [K-1:0]   grant    [NI];
   logic [15:0]    drop_cnt [NI];
   logic [15:0]    abort_cnt[NI];

   axis_frame_arbiter #(.N(N), .K(K), .FRAME_BEATS(2)) dut0 (
      .clk(clk), .rst(rst),
      .s_axis_tvalid(s_valid[0]), .s_axis_tdata(s_data[0]), .s_axis_tfirst(s_first[0]),
      .s_axis_tnext(s_tnext[0]), .m_axis_tnext(m_next[0]), .m_axis_tdata(m_data[0]),
      .m_axis_tfirst(m_first[0]), .m_axis_tvalid(m_valid[0]), .grant(grant[0]),
      .drop_count(drop_cnt[0]), .abort_count(abort_cnt[0]));

   axis_frame_arbiter #(.N(N), .K(K), .FRAME_BEATS(4)) dut1 (
      .clk(clk), .rst(rst),
      .s_axis_tvalid(s_valid[1]), .s_axis_tdata(s_data[1]), .s_axis_tfirst(s_first[1]),
      .s_axis_tnext(s_tnext[1]), .m_axis_tnext(m_next[1]), .m_axis_tdata(m_data[1]),
      .m_axis_tfirst(m_first[1]), .m_axis_tvalid(m_valid[1]), .grant(grant[1]),
      .drop_count(drop_cnt[1]), .abort_count(abort_cnt[1]));

   int checks = 0;
   int passed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: actual %0h required %0h", name, act, exp);
   endtask

   // ---------------- reference model (frame level) ----------------
   int fb        [NI] = '{2, 4};
   int mo_owner  [NI];   // -1 when no frame is open
   int mo_done   [NI];   // beats already delivered in the open frame
   int mo_last   [NI];
   int mo_drops  [NI];
   int mo_aborts [NI];

   task automatic model_cycle(input int ix, input logic mv, input logic [N-1:0] md,
                              input logic mf, input logic [K-1:0] tn, input logic [K-1:0] gr,
                              input logic [15:0] dc, input logic [15:0] ac, input logic [15:0] cnt);
      logic e_mv, e_mf;
      logic [N-1:0] e_md;
      logic [K-1:0] e_tn, e_gr;
      int e_cnt, o, c;
      bit ab, data_chk;
      string p;
      p = $sformatf("i%0d", ix);
      ab = 1'b0; o = 0; data_chk = 1'b1;
      e_mv = 1'b0; e_mf = 1'b0; e_md = '0; e_tn = '0; e_gr = '0; e_cnt = 0;
      if (rst) begin
         mo_owner[ix] = -1; mo_done[ix] = 0; mo_last[ix] = K - 1;
         mo_drops[ix] = 0;  mo_aborts[ix] = 0;
      end else if (mo_owner[ix] < 0) begin
         e_tn = s_valid[ix] & ~s_first[ix];
         data_chk = 1'b0;
      end else begin
         o     = mo_owner[ix];
         ab    = s_valid[ix][o] && s_first[ix][o] && (mo_done[ix] != 0);
         e_mv  = s_valid[ix][o] && !ab;
         e_mf  = s_first[ix][o];
         e_md  = s_data[ix][o*N +: N];
         e_tn  = (e_mv && m_next[ix]) ? (K'(1) << o) : '0;
         e_gr  = K'(1) << o;
         e_cnt = fb[ix] - 1 - mo_done[ix];
      end
      check({p, "_tvalid"}, mv, e_mv);
      check({p, "_tnext"}, tn, e_tn);
      check({p, "_grant"}, gr, e_gr);
      check({p, "_drop_count"}, dc, mo_drops[ix]);
      check({p, "_abort_count"}, ac, mo_aborts[ix]);
      check({p, "_counter"}, cnt, e_cnt);
      if (data_chk) begin
         check({p, "_tdata"}, md, e_md);
         check({p, "_tfirst"}, mf, e_mf);
      end
      if (!rst) begin
         if (mo_owner[ix] < 0) begin
            mo_drops[ix] = (mo_drops[ix] + $countones(e_tn) > 65535) ? 65535
                           : mo_drops[ix] + $countones(e_tn);
            for (int j = 1; j <= K; j++) begin
               c = (mo_last[ix] + j) % K;
               if (mo_owner[ix] < 0 && s_valid[ix][c] && s_first[ix][c]) begin
                  mo_owner[ix] = c;
                  mo_done[ix]  = 0;
               end
            end
         end else if (ab) begin
            mo_aborts[ix] = (mo_aborts[ix] == 65535) ? 65535 : mo_aborts[ix] + 1;
            mo_last[ix]   = o;
            mo_owner[ix]  = -1;
         end else if (e_mv && m_next[ix]) begin
            mo_done[ix]++;
            if (mo_done[ix] == fb[ix]) begin
               mo_last[ix]  = o;
               mo_owner[ix] = -1;
            end
         end
      end
   endtask

   always @(negedge clk) begin
      model_cycle(0, m_valid[0], m_data[0], m_first[0], s_tnext[0], grant[0],
                  drop_cnt[0], abort_cnt[0], dut0.state_r.count);
      model_cycle(1, m_valid[1], m_data[1], m_first[1], s_tnext[1], grant[1],
                  drop_cnt[1], abort_cnt[1], dut1.state_r.count);
   end

   // ---------------- frame sources ----------------
   int junk [NI][K];   // misaligned beats to present before the next frame
   int flen [NI][K];   // length of the current frame (0 = nothing to send)
   int nlen [NI][K];   // length of subsequent frames
   int pos  [NI][K];
   int nfr  [NI][K];   // frames remaining after the current one
   bit rmode;
   logic mforce [NI];

   task automatic clear_sources();
      for (int ix = 0; ix < NI; ix++) begin
         mforce[ix] = 1'b1;
         for (int i = 0; i < K; i++) begin
            junk[ix][i] = 0; flen[ix][i] = 0; nlen[ix][i] = 0; pos[ix][i] = 0; nfr[ix][i] = 0;
         end
      end
   endtask

   task automatic drive_inputs();
      logic [K-1:0] v, f;
      logic [K*N-1:0] d;
      bit act;
      for (int ix = 0; ix < NI; ix++) begin
         v = '0; f = '0; d = '0;
         for (int i = 0; i < K; i++) begin
            act = (junk[ix][i] > 0) || (pos[ix][i] < flen[ix][i]);
            if (act) begin
               v[i] = rmode ? ($urandom_range(0, 99) < 75) : 1'b1;
               f[i] = (junk[ix][i] == 0) && (pos[ix][i] == 0);
               d[i*N +: N] = rmode ? N'($urandom) : N'(i * 3 + pos[ix][i] + 1);
            end
         end
         s_valid[ix] = v; s_first[ix] = f; s_data[ix] = d;
         m_next[ix]  = rmode ? ($urandom_range(0, 99) < 70) : mforce[ix];
      end
   endtask

   task automatic advance(input int ix, input logic [K-1:0] tn);
      for (int i = 0; i < K; i++) begin
         if (tn[i] && s_valid[ix][i]) begin
            if (junk[ix][i] > 0) junk[ix][i]--;
            else begin
               pos[ix][i]++;
               if (pos[ix][i] >= flen[ix][i]) begin
                  pos[ix][i] = 0;
                  if (nfr[ix][i] > 0) begin nfr[ix][i]--; flen[ix][i] = nlen[ix][i]; end
                  else flen[ix][i] = 0;
               end
            end
         end
      end
   endtask

   task automatic refill();
      for (int ix = 0; ix < NI; ix++)
         for (int i = 0; i < K; i++)
            if (junk[ix][i] == 0 && flen[ix][i] == 0 && $urandom_range(0, 3) == 0) begin
               junk[ix][i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
               flen[ix][i] = $urandom_range(1, 6);
               nlen[ix][i] = $urandom_range(1, 6);
               nfr[ix][i]  = $urandom_range(0, 2);
               pos[ix][i]  = 0;
            end
   endtask

   // Samples taken on the falling edge of the cycle just completed.
   logic [K-1:0] smp_grant [NI];
   logic [K-1:0] smp_tn    [NI];
   logic         smp_mv    [NI];
   logic [N-1:0] smp_md    [NI];
   logic [15:0]  smp_dc    [NI];
   logic [15:0]  smp_ac    [NI];
   logic [15:0]  smp_cnt   [NI];

   task automatic cycle();
      @(negedge clk);
      for (int ix = 0; ix < NI; ix++) begin
         smp_grant[ix] = grant[ix]; smp_tn[ix] = s_tnext[ix]; smp_mv[ix] = m_valid[ix];
         smp_md[ix] = m_data[ix]; smp_dc[ix] = drop_cnt[ix]; smp_ac[ix] = abort_cnt[ix];
      end
      smp_cnt[0] = dut0.state_r.count;
      smp_cnt[1] = dut1.state_r.count;
      @(posedge clk);
      #1;
      advance(0, smp_tn[0]);
      advance(1, smp_tn[1]);
      if (rmode) refill();
      drive_inputs();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_sources();
      drive_inputs();
      cycle();
      cycle();
      rst = 1'b0;
   endtask

   logic [K-1:0] lg_g  [64];
   logic         lg_mv [64];
   logic [K-1:0] lg_tn [64];
   logic [N-1:0] lg_md [64];
   int seq [8];

   task automatic run_log(input int ix, input int n);
      for (int c = 0; c < n; c++) begin
         cycle();
         lg_g[c] = smp_grant[ix]; lg_mv[c] = smp_mv[ix];
         lg_tn[c] = smp_tn[ix];   lg_md[c] = smp_md[ix];
      end
   endtask

   // Owners in the order their frames were granted, from the logged grants.
   task automatic owner_seq(input int n);
      int k;
      k = 0;
      for (int c = 0; c < 8; c++) seq[c] = -1;
      for (int c = 0; c < n; c++)
         if (lg_g[c] != '0 && (c == 0 || lg_g[c-1] == '0) && k < 8) begin
            for (int i = 0; i < K; i++) if (lg_g[c][i]) seq[k] = i;
            k++;
         end
   endtask

   initial begin
      rst = 1'b1;
      rmode = 1'b0;
      clear_sources();
      drive_inputs();
      cycle();
      check("reset_grant", smp_grant[0], 4'b0000);
      check("reset_tvalid", smp_mv[0], 1'b0);
      check("reset_drop", smp_dc[0], 16'd0);

      // Simultaneous first beats on 0 and 2: 0 wins, one bubble, then 2.
      do_reset();
      flen[0][0] = 2; flen[0][2] = 2;
      drive_inputs();
      run_log(0, 7);
      check("rr_g0", lg_g[0], 4'b0000);
      check("rr_g1", lg_g[1], 4'b0001);
      check("rr_g2", lg_g[2], 4'b0001);
      check("rr_g3", lg_g[3], 4'b0000);
      check("rr_g4", lg_g[4], 4'b0100);
      check("rr_g5", lg_g[5], 4'b0100);
      check("rr_g6", lg_g[6], 4'b0000);
      check("rr_v0", lg_mv[0], 1'b0);
      check("rr_d1", lg_md[1], 4'd1);
      check("rr_d2", lg_md[2], 4'd2);
      check("rr_v3", lg_mv[3], 1'b0);
      check("rr_d4", lg_md[4], 4'd7);
      check("rr_d5", lg_md[5], 4'd8);

      // All four framed continuously: strict rotation.
      do_reset();
      for (int i = 0; i < K; i++) begin flen[0][i] = 2; nlen[0][i] = 2; nfr[0][i] = 10; end
      drive_inputs();
      run_log(0, 40);
      owner_seq(40);
      check("fair_0", seq[0], 0);
      check("fair_1", seq[1], 1);
      check("fair_2", seq[2], 2);
      check("fair_3", seq[3], 3);
      check("fair_4", seq[4], 0);

      // Misaligned beats in idle are drained and counted.
      do_reset();
      junk[0][1] = 3;
      drive_inputs();
      for (int c = 0; c < 3; c++) begin
         cycle();
         check($sformatf("drop_tnext_%0d", c), smp_tn[0], 4'b0010);
      end
      cycle();
      check("drop_count", smp_dc[0], 16'd3);
      check("drop_tnext_end", smp_tn[0], 4'b0000);

      // Early tfirst on beat 2 of a 4-beat frame aborts it.
      do_reset();
      flen[1][0] = 1; nlen[1][0] = 4; nfr[1][0] = 1;
      flen[1][1] = 4; flen[1][2] = 4;
      drive_inputs();
      run_log(1, 24);
      check("abort_xfer_g", lg_g[1], 4'b0001);
      check("abort_xfer_tn", lg_tn[1], 4'b0001);
      check("abort_g", lg_g[2], 4'b0001);
      check("abort_tvalid", lg_mv[2], 1'b0);
      check("abort_tnext", lg_tn[2], 4'b0000);
      check("abort_idle", lg_g[3], 4'b0000);
      owner_seq(24);
      check("abort_seq0", seq[0], 0);
      check("abort_seq1", seq[1], 1);
      check("abort_seq2", seq[2], 2);
      check("abort_seq3", seq[3], 0);
      check("abort_count", smp_ac[1], 16'd1);

      // Sink stalls for 5 cycles mid-frame.
      do_reset();
      flen[0][0] = 2;
      drive_inputs();
      cycle();
      cycle();
      mforce[0] = 1'b0;
      drive_inputs();
      for (int c = 0; c < 5; c++) begin
         cycle();
         check($sformatf("stall_g_%0d", c), smp_grant[0], 4'b0001);
         check($sformatf("stall_v_%0d", c), smp_mv[0], 1'b1);
         check($sformatf("stall_d_%0d", c), smp_md[0], 4'd2);
         check($sformatf("stall_tn_%0d", c), smp_tn[0], 4'b0000);
         check($sformatf("stall_cnt_%0d", c), smp_cnt[0], 16'd0);
      end
      mforce[0] = 1'b1;
      drive_inputs();
      cycle();
      check("stall_release_tn", smp_tn[0], 4'b0001);
      cycle();
      check("stall_done_g", smp_grant[0], 4'b0000);

      // Reset mid-frame, then arbitration restarts from requester 0.
      do_reset();
      flen[0][2] = 2;
      drive_inputs();
      cycle();
      cycle();
      rst = 1'b1;
      clear_sources();
      flen[0][1] = 2; flen[0][3] = 2;
      drive_inputs();
      cycle();
      check("rst_mid_g", smp_grant[0], 4'b0000);
      check("rst_mid_v", smp_mv[0], 1'b0);
      check("rst_mid_tn", smp_tn[0], 4'b0000);
      check("rst_mid_d", smp_md[0], 4'd0);
      rst = 1'b0;
      cycle();
      check("rst_after_idle", smp_grant[0], 4'b0000);
      cycle();
      check("rst_after_g", smp_grant[0], 4'b0010);
      check("rst_after_abort", smp_ac[0], 16'd0);

      // Randomized traffic on both instances with occasional resets.
      do_reset();
      rmode = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         if (c % 700 == 699) rst = 1'b1;
         cycle();
         rst = 1'b0;
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
